// File: rtl/hm_hash_sequencer.sv
// Double-SHA256 nonce sweep controller: builds the three message blocks for each
// nonce, sequences the SHA-256 core through them and hands out each digest.
module hm_hash_sequencer #(
    parameter int ROUNDS     = 64,
    parameter int LEN_BLOCK2 = 640,
    parameter int LEN_BLOCK3 = 256
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [18:0][31:0] header,
    input  logic [31:0]       nonce_start,
    input  logic [31:0]       nonce_end,
    input  logic [7:0][31:0]  core_hash,
    output logic [15:0][31:0] data,
    output logic [6:0]        count,
    output logic              init,
    output logic              clear,
    output logic              out_load,
    output logic [1:0]        hash_select,
    output logic              halt,
    output logic              busy,
    output logic              hash_valid,
    input  logic              hash_ready,
    output logic [7:0][31:0]  hash_out,
    output logic [31:0]       hash_nonce,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);
    localparam logic [1:0] BLK1     = 2'd0;
    localparam logic [1:0] BLK2     = 2'd1;
    localparam logic [1:0] BLK3     = 2'd2;

    logic [2:0]        state;
    logic [1:0]        blk;
    logic [6:0]        rnd;
    logic [18:0][31:0] hdr_q;
    logic [31:0]       nonce_q;
    logic [31:0]       nonce_end_q;
    logic [7:0][31:0]  dig_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            blk         <= BLK1;
            rnd         <= '0;
            hdr_q       <= '0;
            nonce_q     <= '0;
            nonce_end_q <= '0;
            dig_q       <= '0;
            hash_out    <= '0;
            hash_nonce  <= '0;
            hash_valid  <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            blk        <= BLK1;
            rnd        <= '0;
            hash_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hdr_q       <= header;
                        nonce_q     <= nonce_start;
                        nonce_end_q <= nonce_end;
                        blk         <= BLK1;
                        state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    rnd   <= '0;
                    state <= S_ROUND;
                    // first-pass digest is only visible on core_hash until the next out_load
                    if (blk == BLK3)
                        dig_q <= core_hash;
                end
                S_ROUND: begin
                    if (rnd == LAST_RND)
                        state <= S_LOAD;
                    else
                        rnd <= rnd + 7'd1;
                end
                S_LOAD: begin
                    if (blk == BLK3) begin
                        state <= S_REPORT;
                    end else begin
                        blk   <= blk + 2'd1;
                        state <= S_INIT;
                    end
                end
                S_REPORT: begin
                    // hash_valid low on entry doubles as the capture phase
                    if (!hash_valid) begin
                        hash_out   <= core_hash;
                        hash_nonce <= nonce_q;
                        hash_valid <= 1'b1;
                    end else if (hash_ready) begin
                        hash_valid <= 1'b0;
                        if (nonce_q == nonce_end_q) begin
                            state <= S_FIN;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                            blk     <= BLK1;
                            state   <= S_INIT;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic active;
    assign active      = (state == S_INIT) || (state == S_ROUND) || (state == S_LOAD);
    assign busy        = (state != S_IDLE);
    assign init        = (state == S_INIT);
    assign out_load    = (state == S_LOAD);
    assign halt        = !((state == S_INIT) || (state == S_ROUND));
    assign done        = (state == S_FIN);
    assign hash_select = active ? blk : 2'b00;
    assign clear       = active && (blk != BLK2);
    assign count       = (state == S_ROUND) ? rnd :
                         (state == S_LOAD)  ? LAST_RND : 7'd0;

    for (genvar w = 0; w < 16; w++) begin : g_word
        logic [31:0] b2_word;
        logic [31:0] b3_word;

        if (w < 3) begin : g_b2_hdr
            assign b2_word = hdr_q[16 + w];
        end else if (w == 3) begin : g_b2_nonce
            assign b2_word = nonce_q;
        end else if (w == 4) begin : g_b2_pad
            assign b2_word = 32'h8000_0000;
        end else if (w == 15) begin : g_b2_len
            assign b2_word = 32'(LEN_BLOCK2);
        end else begin : g_b2_zero
            assign b2_word = '0;
        end

        if (w < 8) begin : g_b3_dig
            assign b3_word = (state == S_INIT) ? core_hash[w] : dig_q[w];
        end else if (w == 8) begin : g_b3_pad
            assign b3_word = 32'h8000_0000;
        end else if (w == 15) begin : g_b3_len
            assign b3_word = 32'(LEN_BLOCK3);
        end else begin : g_b3_zero
            assign b3_word = '0;
        end

        assign data[w] = !active      ? 32'h0    :
                         (blk == BLK1) ? hdr_q[w] :
                         (blk == BLK2) ? b2_word  :
                         (blk == BLK3) ? b3_word  : 32'h0;
    end

endmodule

// File: tb/tb_hm_hash_sequencer.sv
// Bench for hm_hash_sequencer: a bus-level SHA-256 core model answers the
// sequencer, and every digest is checked against a message-level double SHA-256.
module tb_hm_hash_sequencer;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic              abort;
    logic [18:0][31:0] header;
    logic [31:0]       nonce_start;
    logic [31:0]       nonce_end;
    logic [7:0][31:0]  core_hash;
    logic [15:0][31:0] data;
    logic [6:0]        count;
    logic              init;
    logic              clear;
    logic              out_load;
    logic [1:0]        hash_select;
    logic              halt;
    logic              busy;
    logic              hash_valid;
    logic              hash_ready;
    logic [7:0][31:0]  hash_out;
    logic [31:0]       hash_nonce;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    hm_hash_sequencer dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .header(header),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .core_hash(core_hash),
        .data(data), .count(count), .init(init), .clear(clear), .out_load(out_load),
        .hash_select(hash_select), .halt(halt), .busy(busy), .hash_valid(hash_valid),
        .hash_ready(hash_ready), .hash_out(hash_out), .hash_nonce(hash_nonce), .done(done));

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] sha_compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [7:0][31:0] r;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
        r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
        return r;
    endfunction

    function automatic logic [7:0][31:0] iv_vec();
        logic [7:0][31:0] v;
        for (int i = 0; i < 8; i++) v[i] = IV[i];
        return v;
    endfunction

    // plain SHA-256 of a word-aligned message, padding done from the message length
    function automatic logic [7:0][31:0] sha256_msg(input logic [31:0] msg [$]);
        logic [31:0]       m [$];
        logic [15:0][31:0] blk;
        logic [7:0][31:0]  h;
        m = msg;
        m.push_back(32'h8000_0000);
        while (m.size() % 16 != 14) m.push_back(32'h0);
        m.push_back(32'h0);
        m.push_back(32'(msg.size() * 32));
        h = iv_vec();
        for (int b = 0; b < m.size() / 16; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = m[b*16 + i];
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    function automatic logic [7:0][31:0] ref_hash(input logic [18:0][31:0] hdr, input logic [31:0] nonce);
        logic [31:0]      q [$];
        logic [7:0][31:0] h1;
        for (int i = 0; i < 19; i++) q.push_back(hdr[i]);
        q.push_back(nonce);
        h1 = sha256_msg(q);
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(h1[i]);
        return sha256_msg(q);
    endfunction

    // Bus-level core: takes the block and chaining value at init, publishes on out_load.
    logic [7:0][31:0]  chain_m;
    logic [15:0][31:0] blk_m;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            core_hash <= '0;
            chain_m   <= '0;
            blk_m     <= '0;
        end else begin
            if (init) begin
                chain_m <= clear ? iv_vec() : core_hash;
                blk_m   <= data;
            end
            if (out_load) core_hash <= sha_compress(chain_m, blk_m);
        end
    end

    logic [2:0] sel_q [$];
    int         data_glitch = 0;
    always @(negedge clk) begin
        if (init) sel_q.push_back({clear, hash_select});
        if (n_rst && !init && !halt && data !== blk_m) data_glitch++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rand_hdr(output logic [18:0][31:0] hdr);
        for (int i = 0; i < 19; i++) hdr[i] = $urandom;
    endtask

    task automatic do_start(input logic [18:0][31:0] hdr, input logic [31:0] ns, input logic [31:0] ne);
        @(posedge clk); #1;
        header = hdr; nonce_start = ns; nonce_end = ne; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic get_digest(output logic [7:0][31:0] h, output logic [31:0] n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (hash_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        h = hash_out;
        n = hash_nonce;
    endtask

    task automatic accept();
        hash_ready = 1'b1;
        @(posedge clk); #1;
        hash_ready = 1'b0;
    endtask

    // Sweep [ns, ns+n-1]; optionally stall the first report and/or pulse start mid-block.
    task automatic run_check(input string tag, input logic [18:0][31:0] hdr, input logic [31:0] ns,
                             input int n, input int hold, input bit inject);
        logic [7:0][31:0] h, h0;
        logic [31:0]      nn, n0, exp_n;
        bit               ok, stable;
        logic [2:0]       s0, s1, s2;
        do_start(hdr, ns, ns + 32'(n - 1));
        sel_q.delete();
        if (inject) begin
            repeat (10) @(posedge clk);
            #1;
            header = ~hdr; nonce_start = $urandom; nonce_end = $urandom; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            exp_n = ns + 32'(k);
            get_digest(h, nn, ok);
            chk({tag, " valid"}, 256'(ok), 256'(1'b1));
            chk({tag, " nonce"}, 256'(nn), 256'(exp_n));
            chk({tag, " digest"}, h, ref_hash(hdr, exp_n));
            if (sel_q.size() == 3) begin s0 = sel_q[0]; s1 = sel_q[1]; s2 = sel_q[2]; end
            else begin s0 = 'x; s1 = 'x; s2 = 'x; end
            chk({tag, " clear/select"}, 256'({s0, s1, s2}), 256'(9'b1_00_0_01_1_10));
            sel_q.delete();
            if (k == 0 && hold > 0) begin
                h0 = hash_out; n0 = hash_nonce; stable = 1'b1;
                repeat (hold) begin
                    @(posedge clk); #1;
                    if (!hash_valid || hash_out !== h0 || hash_nonce !== n0 || !halt || init) stable = 1'b0;
                end
                chk({tag, " stall hold"}, 256'(stable), 256'(1'b1));
            end
            accept();
            chk({tag, " done"}, 256'(done), 256'(k == n - 1));
        end
        @(posedge clk); #1;
        chk({tag, " idle"}, 256'(busy), 256'(1'b0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0][31:0] hdr;
        logic [7:0][31:0]  h;
        logic [31:0]       nn;
        bit                ok, good, quiet;

        n_rst = 1'b0; start = 1'b0; abort = 1'b0; hash_ready = 1'b0;
        header = '0; nonce_start = '0; nonce_end = '0;
        #12;
        chk("rst busy", 256'(busy), 256'(1'b0));
        chk("rst halt", 256'(halt), 256'(1'b1));
        chk("rst ctrl", 256'({init, out_load, clear, hash_select, count, hash_valid, done}), 256'(0));
        chk("rst data", 256'(data), 256'(0));
        chk("rst hash", {hash_out}, 256'(0));
        chk("rst nonce", 256'(hash_nonce), 256'(0));
        n_rst = 1'b1;

        // genesis block: header nonce bytes 1d ac 2b 7c encode nonce 0x7C2BAC1D
        hdr = '0;
        hdr[0] = 32'h01000000;
        hdr[9]  = 32'h3ba3edfd; hdr[10] = 32'h7a7b12b2; hdr[11] = 32'h7ac72c3e; hdr[12] = 32'h67768f61;
        hdr[13] = 32'h7fc81bc3; hdr[14] = 32'h888a5132; hdr[15] = 32'h3a9fb8aa; hdr[16] = 32'h4b1e5e4a;
        hdr[17] = 32'h29ab5f49; hdr[18] = 32'hffff001d;
        do_start(hdr, 32'h1dac2b7c, 32'h1dac2b7c);
        sel_q.delete();
        chk("blk1 init", 256'({init, halt, count, out_load}), 256'({1'b1, 1'b0, 7'd0, 1'b0}));
        chk("blk1 data", 256'(data), 256'(hdr[15:0]));
        @(posedge clk); #1;
        chk("blk1 init width", 256'(init), 256'(1'b0));
        good = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (init || halt || out_load || count !== 7'(i)) good = 1'b0;
        end
        chk("blk1 round count", 256'(good), 256'(1'b1));
        @(posedge clk); #1;
        chk("blk1 load", 256'({out_load, halt, count}), 256'({1'b1, 1'b1, 7'd63}));
        @(posedge clk); #1;
        chk("blk2 init", 256'({init, hash_select, clear}), 256'({1'b1, 2'b01, 1'b0}));
        chk("blk2 nonce word", 256'(data[3]), 256'(32'h1dac2b7c));
        get_digest(h, nn, ok);
        chk("genesis valid", 256'(ok), 256'(1'b1));
        chk("genesis word0", 256'(h[0]), 256'(32'h6fe28c0a));
        chk("genesis word7", 256'(h[7]), 256'(32'h00000000));
        chk("genesis digest", h, ref_hash(hdr, 32'h1dac2b7c));
        chk("genesis nonce", 256'(nn), 256'(32'h1dac2b7c));
        accept();
        chk("genesis done", 256'(done), 256'(1'b1));
        @(posedge clk); #1;
        chk("genesis done pulse", 256'({done, busy}), 256'(0));

        rand_hdr(hdr);
        run_check("wrap", hdr, 32'hffff_ffff, 3, 0, 1'b0);

        rand_hdr(hdr);
        run_check("stall", hdr, $urandom, 2, 20, 1'b0);

        rand_hdr(hdr);
        run_check("start busy", hdr, $urandom, 2, 0, 1'b1);

        // abort in blk2 round 30
        rand_hdr(hdr);
        do_start(hdr, 32'h10, 32'h15);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (hash_select == 2'b01 && count == 7'd30 && !init) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("abort reach", 256'(ok), 256'(1'b1));
        abort = 1'b1; hash_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; hash_ready = 1'b0;
        chk("abort idle", 256'({busy, hash_valid, done, halt}), 256'({1'b0, 1'b0, 1'b0, 1'b1}));
        quiet = 1'b1;
        repeat (300) begin
            @(posedge clk); #1;
            if (hash_valid || done || busy || !halt) quiet = 1'b0;
        end
        chk("abort quiet", 256'(quiet), 256'(1'b1));
        rand_hdr(hdr);
        run_check("after abort", hdr, $urandom, 1, 0, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start+abort", 256'(busy), 256'(1'b0));

        // async reset mid-sweep
        rand_hdr(hdr);
        do_start(hdr, $urandom, $urandom);
        repeat (150) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("midrst state", 256'({busy, halt, hash_valid, done, init}), 256'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("midrst data", 256'(data), 256'(0));
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int r = 0; r < 3; r++) begin
            rand_hdr(hdr);
            run_check("random", hdr, (r == 0) ? 32'hffff_fffe : $urandom, 1 + (r % 2), 0, 1'b0);
        end

        chk("data held per block", 256'(data_glitch), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
